// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped write-through cache controller.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_RD   = 2'd1,
        MEM_WAIT = 2'd2,
        MEM_WR   = 2'd3
    } state_t;

    localparam int STAT_WIDTH = 16;

    // Low index_bits of a word address select the cache line.
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_bits);
        return addr & ((32'd1 << index_bits) - 32'd1);
    endfunction

    // Remaining upper bits form the tag stored alongside the line.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_bits);
        return addr >> index_bits;
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Processor request bus and main-memory port bundled for the cache controller.
interface cache_controller_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ready;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic                  mem_enable;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;

    // Controller side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_read_data,
        output cpu_ready, cpu_rvalid, cpu_rdata,
        output mem_enable, mem_read, mem_write, mem_address, mem_write_data
    );

    // Requester plus memory side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_read_data,
        input  cpu_ready, cpu_rvalid, cpu_rdata,
        input  mem_enable, mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays for a direct-mapped cache of one-word lines.
// Combinational lookup, single synchronous write port, valid bits cleared on reset.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 4,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [INDEX_BITS-1:0] lookup_index,
    input  logic [TAG_WIDTH-1:0]  lookup_tag,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  write_en,
    input  logic [INDEX_BITS-1:0] write_index,
    input  logic [TAG_WIDTH-1:0]  write_tag,
    input  logic [DATA_WIDTH-1:0] write_data
);
    localparam int LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0]      valid_reg;
    logic [TAG_WIDTH-1:0]  tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES];

    // A write always leaves its line valid: fills set it, hit updates find it already set.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    valid_reg[gi] <= 1'b0;
                end else if (write_en && (write_index == INDEX_BITS'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (write_en) begin
            tag_mem[write_index]  <= write_tag;
            data_mem[write_index] <= write_data;
        end
    end

    assign hit   = valid_reg[lookup_index] && (tag_mem[lookup_index] == lookup_tag);
    assign rdata = data_mem[lookup_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller with fixed-latency memory reads.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_controller
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int INDEX_BITS  = 4,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    cache_controller_if.slave     bus
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] miss_count
`endif
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_BITS;
    localparam int CNT_WIDTH = $clog2(MEM_LATENCY + 1);

    state_t                state_reg, state_next;
    logic [CNT_WIDTH-1:0]  count_reg, count_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic                  rvalid_reg, rvalid_next;

    logic                  accept;
    logic [INDEX_BITS-1:0] req_index, fill_index;
    logic [TAG_WIDTH-1:0]  req_tag, fill_tag;
    logic                  lookup_hit;
    logic [DATA_WIDTH-1:0] lookup_rdata;

    logic                  store_we;
    logic [INDEX_BITS-1:0] store_index;
    logic [TAG_WIDTH-1:0]  store_tag;
    logic [DATA_WIDTH-1:0] store_wdata;

    logic                  mem_enable_comb, mem_read_comb, mem_write_comb;

    assign accept     = bus.cpu_req && (state_reg == IDLE);
    assign req_index  = INDEX_BITS'(addr_index(32'(bus.cpu_addr), INDEX_BITS));
    assign req_tag    = TAG_WIDTH'(addr_tag(32'(bus.cpu_addr), INDEX_BITS));
    assign fill_index = INDEX_BITS'(addr_index(32'(addr_reg), INDEX_BITS));
    assign fill_tag   = TAG_WIDTH'(addr_tag(32'(addr_reg), INDEX_BITS));

    cache_line_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .INDEX_BITS (INDEX_BITS),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_store (
        .clock        (clock),
        .reset_n      (reset_n),
        .lookup_index (req_index),
        .lookup_tag   (req_tag),
        .hit          (lookup_hit),
        .rdata        (lookup_rdata),
        .write_en     (store_we),
        .write_index  (store_index),
        .write_tag    (store_tag),
        .write_data   (store_wdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            rdata_reg  <= rdata_next;
            rvalid_reg <= rvalid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        rdata_next      = rdata_reg;
        rvalid_next     = 1'b0;
        store_we        = 1'b0;
        store_index     = req_index;
        store_tag       = req_tag;
        store_wdata     = bus.cpu_wdata;
        mem_enable_comb = 1'b0;
        mem_read_comb   = 1'b0;
        mem_write_comb  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (bus.cpu_we) begin
                        // Write-through: refresh a resident line, never allocate on a miss.
                        addr_next  = bus.cpu_addr;
                        wdata_next = bus.cpu_wdata;
                        store_we   = lookup_hit;
                        state_next = MEM_WR;
                    end else if (lookup_hit) begin
                        rdata_next  = lookup_rdata;
                        rvalid_next = 1'b1;
                    end else begin
                        addr_next  = bus.cpu_addr;
                        state_next = MEM_RD;
                    end
                end
            end
            MEM_RD: begin
                mem_enable_comb = 1'b1;
                mem_read_comb   = 1'b1;
                count_next      = CNT_WIDTH'(MEM_LATENCY);
                state_next      = MEM_WAIT;
            end
            MEM_WAIT: begin
                // Memory flags are sticky, so completion is timed purely by the counter.
                count_next = count_reg - CNT_WIDTH'(1);
                if (count_reg == CNT_WIDTH'(1)) begin
                    store_we    = 1'b1;
                    store_index = fill_index;
                    store_tag   = fill_tag;
                    store_wdata = bus.mem_read_data;
                    rdata_next  = bus.mem_read_data;
                    rvalid_next = 1'b1;
                    state_next  = IDLE;
                end
            end
            MEM_WR: begin
                mem_enable_comb = 1'b1;
                mem_write_comb  = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.cpu_ready      = (state_reg == IDLE);
    assign bus.cpu_rvalid     = rvalid_reg;
    assign bus.cpu_rdata      = rdata_reg;
    assign bus.mem_enable     = mem_enable_comb;
    assign bus.mem_read       = mem_read_comb;
    assign bus.mem_write      = mem_write_comb;
    assign bus.mem_address    = addr_reg;
    assign bus.mem_write_data = wdata_reg;

`ifdef CACHE_STATS_EN
    logic [STAT_WIDTH-1:0] hit_count_reg, miss_count_reg;

    // Each accepted read bumps exactly one counter; both stick at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else if (accept && !bus.cpu_we) begin
            if (lookup_hit) begin
                if (hit_count_reg != '1) hit_count_reg <= hit_count_reg + STAT_WIDTH'(1);
            end else begin
                if (miss_count_reg != '1) miss_count_reg <= miss_count_reg + STAT_WIDTH'(1);
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed test-plan cases, then random traffic
// compared every cycle against a line-level cache model and a reference memory image.
module tb_cache_controller;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int IB    = 4;
    localparam int LAT   = 1;
    localparam int LINES = 16;
    localparam int WORDS = 1024;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    cache_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    cache_controller #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .INDEX_BITS  (IB),
        .MEM_LATENCY (LAT)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int a);
        return (a == 5) ? 32'hDEADBEEF : (32'hA000_0000 | 32'(a));
    endfunction

    // ---------------- memory emulator (registered read, sticky data) ----------------
    logic [31:0] tb_mem [WORDS];
    int          rd_pulses = 0;
    int          wr_pulses = 0;
    logic [9:0]  last_wr_addr = '0;

    // ---------------- behavioural reference model ----------------
    logic [31:0] ref_mem [WORDS];
    bit          m_valid [LINES];
    int          m_tag   [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] exp_rv  [int];
    logic [9:0]  exp_rd  [int];
    logic [41:0] exp_wr  [int];
    int          cyc = 0;
    int          busy_end = -1;
    logic [31:0] last_rdata = '0;
    int          m_hits = 0;
    int          m_misses = 0;

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            tb_mem[i]  = init_val(i);
            ref_mem[i] = init_val(i);
        end
        bus.mem_read_data = '0;
        forever begin
            logic       s_en, s_rd, s_wr;
            logic [9:0] s_a;
            logic [31:0] s_d;
            @(negedge clock);
            s_en = bus.mem_enable; s_rd = bus.mem_read; s_wr = bus.mem_write;
            s_a  = bus.mem_address; s_d = bus.mem_write_data;
            @(posedge clock);
            if (s_en && s_rd) begin
                bus.mem_read_data <= tb_mem[s_a];
                rd_pulses++;
            end
            if (s_en && s_wr) begin
                tb_mem[s_a] = s_d;
                wr_pulses++;
                last_wr_addr = s_a;
            end
        end
    end

    // Interval n is the clock period following posedge n; accept at edge n acts from interval n.
    task automatic model_accept(input logic we, input logic [9:0] a, input logic [31:0] d);
        int idx = int'(a) % LINES;
        int tg  = int'(a) / LINES;
        bit h   = m_valid[idx] && (m_tag[idx] == tg);
        if (we) begin
            ref_mem[a] = d;
            if (h) m_data[idx] = d;
            exp_wr[cyc] = {a, d};
            busy_end = cyc;
        end else if (h) begin
            exp_rv[cyc] = m_data[idx];
            if (m_hits < 65535) m_hits++;
        end else begin
            exp_rd[cyc] = a;
            exp_rv[cyc + 1 + LAT] = ref_mem[a];
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_data[idx]  = ref_mem[a];
            busy_end = cyc + LAT;
            if (m_misses < 65535) m_misses++;
        end
    endtask

    initial forever begin
        logic s_req, s_we, s_rdy;
        logic [9:0] s_a;
        logic [31:0] s_d;
        @(negedge clock);
        #4;
        s_req = bus.cpu_req; s_we = bus.cpu_we; s_a = bus.cpu_addr; s_d = bus.cpu_wdata;
        s_rdy = (cyc > busy_end);
        @(posedge clock);
        cyc++;
        if (reset_n && s_req && s_rdy) model_accept(s_we, s_a, s_d);
    end

    initial forever begin
        @(negedge reset_n);
        exp_rv.delete(); exp_rd.delete(); exp_wr.delete();
        busy_end = -1; last_rdata = '0; m_hits = 0; m_misses = 0;
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic [41:0] w;
        @(negedge clock);
        chk("cpu_ready", 32'(bus.cpu_ready), 32'(cyc > busy_end));
        chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(exp_rv.exists(cyc)));
        if (exp_rv.exists(cyc)) last_rdata = exp_rv[cyc];
        chk("cpu_rdata", bus.cpu_rdata, last_rdata);
        chk("mem_read", 32'(bus.mem_read), 32'(exp_rd.exists(cyc)));
        chk("mem_write", 32'(bus.mem_write), 32'(exp_wr.exists(cyc)));
        chk("mem_enable", 32'(bus.mem_enable), 32'(exp_rd.exists(cyc) || exp_wr.exists(cyc)));
        if (exp_rd.exists(cyc)) chk("mem_rd_address", 32'(bus.mem_address), 32'(exp_rd[cyc]));
        if (exp_wr.exists(cyc)) begin
            w = exp_wr[cyc];
            chk("mem_wr_address", 32'(bus.mem_address), 32'(w[41:32]));
            chk("mem_write_data", bus.mem_write_data, w[31:0]);
        end
`ifdef CACHE_STATS_EN
        chk("hit_count", 32'(hit_count), 32'(m_hits));
        chk("miss_count", 32'(miss_count), 32'(m_misses));
`endif
    end

    // ---------------- stimulus helpers (entered and left at a negedge) ----------------
    task automatic issue(input logic we, input logic [9:0] a, input logic [31:0] d);
        int t = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        while (!bus.cpu_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) begin
            checks++; errors++;
            $display("FAIL accept_timeout: cpu_ready stayed low %0d cycles, required high", t);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic rd_check(input logic [9:0] a, input logic [31:0] exp, input int exp_lat,
                            input string name);
        int lat = 0;
        issue(1'b0, a, '0);
        bus.cpu_req = 1'b0;
        while (!bus.cpu_rvalid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk({name, "_latency"}, 32'(lat + 1), 32'(exp_lat));
        chk({name, "_data"}, bus.cpu_rdata, exp);
    endtask

    task automatic do_reset();
        bus.cpu_req = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        chk("rst_rdata", bus.cpu_rdata, 32'd0);
        chk("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
        chk("rst_mem_address", 32'(bus.mem_address), 32'd0);
        chk("rst_mem_write_data", bus.mem_write_data, 32'd0);
        chk("rst_ready", 32'(bus.cpu_ready), 32'd1);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        int p0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        @(negedge clock);
        do_reset();

        // Cold miss, then hit on the same word.
        p0 = rd_pulses;
        rd_check(10'h005, 32'hDEADBEEF, 3, "miss_005");
        chk("miss_005_rd_pulses", 32'(rd_pulses - p0), 32'd1);
        p0 = rd_pulses;
        rd_check(10'h005, 32'hDEADBEEF, 1, "hit_005");
        chk("hit_005_rd_pulses", 32'(rd_pulses - p0), 32'd0);

        // Conflict on index 5 evicts and refetches.
        rd_check(10'h015, 32'hA000_0015, 3, "conflict_015");
        rd_check(10'h005, 32'hDEADBEEF, 3, "refetch_005");

        // Write-through to a resident line.
        p0 = wr_pulses;
        issue(1'b1, 10'h005, 32'h0AA5A5A5);
        bus.cpu_req = 1'b0;
        @(negedge clock);
        chk("wr_005_pulses", 32'(wr_pulses - p0), 32'd1);
        chk("wr_005_address", 32'(last_wr_addr), 32'h005);
        rd_check(10'h005, 32'h0AA5A5A5, 1, "raw_hit_005");

        // Write miss does not allocate; the following read fetches the written value.
        issue(1'b1, 10'h123, 32'h1234_5678);
        bus.cpu_req = 1'b0;
        rd_check(10'h123, 32'h1234_5678, 3, "raw_miss_123");

        // Back-to-back hits with the request held.
        issue(1'b0, 10'h005, '0);
        issue(1'b0, 10'h123, '0);
        issue(1'b0, 10'h005, '0);
        bus.cpu_req = 1'b0;
        repeat (2) @(negedge clock);

        // Reset while waiting on memory.
        issue(1'b0, 10'h007, '0);
        bus.cpu_req = 1'b0;
        @(posedge clock);
        #1;
        chk("busy_before_reset", 32'(bus.cpu_ready), 32'd0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        chk("abort_mem_enable", 32'(bus.mem_enable), 32'd0);
        chk("abort_mem_read", 32'(bus.mem_read), 32'd0);
        chk("abort_mem_address", 32'(bus.mem_address), 32'd0);
        chk("abort_ready", 32'(bus.cpu_ready), 32'd1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        rd_check(10'h007, 32'hA000_0007, 3, "after_abort_007");

`ifdef CACHE_STATS_EN
        do_reset();
        rd_check(10'h005, ref_mem[5], 3, "st_miss1");
        rd_check(10'h005, ref_mem[5], 1, "st_hit1");
        rd_check(10'h005, ref_mem[5], 1, "st_hit2");
        rd_check(10'h005, ref_mem[5], 1, "st_hit3");
        rd_check(10'h015, 32'hA000_0015, 3, "st_miss2");
        @(negedge clock);
        chk("stats_hits_3", 32'(hit_count), 32'd3);
        chk("stats_misses_2", 32'(miss_count), 32'd2);
        #2;
        force dut.hit_count_reg = 16'hFFFF;
        m_hits = 65535;
        #1;
        release dut.hit_count_reg;
        @(negedge clock);
        rd_check(10'h015, 32'hA000_0015, 1, "st_sat_hit");
        @(negedge clock);
        chk("stats_hit_saturated", 32'(hit_count), 32'h0000_FFFF);
`endif

        // Random traffic over a small address pool so conflicts and reuse are frequent.
        for (int n = 0; n < 400; n++) begin
            logic [9:0]  a;
            logic        we;
            logic [31:0] d;
            a  = 10'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) a = 10'($urandom_range(0, WORDS - 1));
            we = ($urandom_range(0, 3) == 0);
            d  = $urandom;
            issue(we, a, d);
            if ($urandom_range(0, 2) == 0) begin
                bus.cpu_req = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clock);
            end
        end
        bus.cpu_req = 1'b0;
        repeat (6) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
